// File: rtl/alu_seq_ctrl.sv
// Execute-stage controller for the shared 64-bit ALU: one op per request, result + flags on a response channel.
// Optional shift-add multiply sequencer (op 4) is built when ALU_SEQ_MUL_EN is defined.
module alu_seq_ctrl #(
  parameter int unsigned BIT_WID        = 64,
  parameter int unsigned MUL_EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [BIT_WID-1:0] req_a,
  input  logic [BIT_WID-1:0] req_b,
  input  logic               req_setcc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BIT_WID-1:0] rsp_val,
  output logic [3:0]         rsp_cc,
  output logic [3:0]         cc_q,
  output logic [1:0]         alu_fun,
  output logic [BIT_WID-1:0] alu_a,
  output logic [BIT_WID-1:0] alu_b,
  input  logic [BIT_WID-1:0] alu_vale,
  input  logic [3:0]         alu_cc
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_e;
  localparam int unsigned CNT_W = (BIT_WID > 1) ? $clog2(BIT_WID) : 1;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam bit unused_early_exit = (MUL_EARLY_EXIT != 0);
`endif

  state_e             state_q, state_d;
  logic [1:0]         fun_q, fun_d;
  logic [BIT_WID-1:0] a_q, a_d;
  logic [BIT_WID-1:0] b_q, b_d;
  logic               setcc_q, setcc_d;
  logic [BIT_WID-1:0] rsp_val_q, rsp_val_d;
  logic [3:0]         rsp_cc_q, rsp_cc_d;
  logic [3:0]         cc_d;

`ifdef ALU_SEQ_MUL_EN
  logic [BIT_WID-1:0] acc_q, acc_d;
  logic [BIT_WID-1:0] m_q, m_d;
  logic [BIT_WID-1:0] r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_WID-1:0] acc_nxt;
  logic [3:0]         mul_cc;
  logic               mul_done;
`else
  logic               unused_op_hi;
  assign unused_op_hi = req_op[2];
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_val   = rsp_val_q;
  assign rsp_cc    = rsp_cc_q;

  always_comb begin
    state_d   = state_q;
    fun_d     = fun_q;
    a_d       = a_q;
    b_d       = b_q;
    setcc_d   = setcc_q;
    rsp_val_d = rsp_val_q;
    rsp_cc_d  = rsp_cc_q;
    cc_d      = cc_q;
    alu_fun   = fun_q;
    alu_a     = a_q;
    alu_b     = b_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d     = acc_q;
    m_d       = m_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    acc_nxt   = acc_q;
    mul_cc    = '0;
    mul_done  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          fun_d   = req_op[1:0];
          a_d     = req_a;
          b_d     = req_b;
          setcc_d = req_setcc;
          state_d = EXEC;
`ifdef ALU_SEQ_MUL_EN
          if (req_op == 3'd4) begin
            acc_d   = '0;
            m_d     = req_b;
            r_d     = req_a;
            cnt_d   = '0;
            state_d = MUL;
          end
`endif
        end
      end
      EXEC: begin
        rsp_val_d = alu_vale;
        rsp_cc_d  = alu_cc;
        if (setcc_q) cc_d = alu_cc;
        state_d = RESP;
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        // ALU computes acc + m; keep it only when the current multiplier bit is set
        alu_fun  = 2'b00;
        alu_a    = m_q;
        alu_b    = acc_q;
        acc_nxt  = r_q[0] ? alu_vale : acc_q;
        acc_d    = acc_nxt;
        m_d      = m_q << 1;
        r_d      = r_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        mul_done = (cnt_q == CNT_W'(BIT_WID - 1)) ||
                   ((MUL_EARLY_EXIT != 0) && (r_d == '0));
        mul_cc   = {2'b00, acc_nxt[BIT_WID-1], (acc_nxt == '0)};
        if (mul_done) begin
          rsp_val_d = acc_nxt;
          rsp_cc_d  = mul_cc;
          if (setcc_q) cc_d = mul_cc;
          state_d = RESP;
        end
      end
`endif
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fun_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      setcc_q   <= 1'b0;
      rsp_val_q <= '0;
      rsp_cc_q  <= '0;
      cc_q      <= 4'b0001;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= '0;
      m_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      fun_q     <= fun_d;
      a_q       <= a_d;
      b_q       <= b_d;
      setcc_q   <= setcc_d;
      rsp_val_q <= rsp_val_d;
      rsp_cc_q  <= rsp_cc_d;
      cc_q      <= cc_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= acc_d;
      m_q       <= m_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
